// File: rtl/e203_exu_muldiv_wbck_buf.sv
// Writeback buffer behind the muldiv unit: tags results with the issue-time ITAG
// and queues {wdat, err, itag} so a slow writeback arbiter never stalls the datapath.
module e203_exu_muldiv_wbck_buf #(
  parameter int DEPTH  = 2,
  parameter int PTR_W  = 1,
  parameter int XLEN   = 32,
  parameter int ITAG_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic              issue_ready,
  input  logic [ITAG_W-1:0] issue_itag,
  input  logic              flush_pulse,
  input  logic              mdv_o_valid,
  output logic              mdv_o_ready,
  input  logic [XLEN-1:0]   mdv_o_wdat,
  input  logic              mdv_o_err,
  output logic              wbck_o_valid,
  input  logic              wbck_o_ready,
  output logic [XLEN-1:0]   wbck_o_wdat,
  output logic              wbck_o_err,
  output logic [ITAG_W-1:0] wbck_o_itag,
  output logic              issue_block,
  output logic [PTR_W:0]    buf_cnt
);

  localparam int ENT_W = XLEN + 1 + ITAG_W;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic              pend_vld_r;
  logic [ITAG_W-1:0] pend_itag_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic [PTR_W:0]    count_nxt_s;
  logic [ENT_W-1:0]  entry_r [DEPTH];

  logic issue_hs_s;
  logic res_hs_s;
  logic pop_s;
  logic full_s;
  logic empty_s;

  assign full_s     = (count_r == DEPTH_C);
  assign empty_s    = (count_r == (PTR_W+1)'(0));
  assign issue_hs_s = issue_valid & issue_ready;
  assign res_hs_s   = mdv_o_valid & ~full_s;
  assign pop_s      = ~empty_s & wbck_o_ready;

  // Pending-op tag: flush cancels, a new issue wins over a same-cycle result clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_r  <= 1'b0;
      pend_itag_r <= '0;
    end else if (flush_pulse) begin
      pend_vld_r  <= 1'b0;
    end else if (issue_hs_s) begin
      pend_vld_r  <= 1'b1;
      pend_itag_r <= issue_itag;
    end else if (res_hs_s) begin
      pend_vld_r  <= 1'b0;
    end
  end

  // Occupancy next-state from push/pop handshakes
  always_comb begin
    count_nxt_s = count_r;
    case ({res_hs_s, pop_s})
      2'b10:   count_nxt_s = count_r + (PTR_W+1)'(1);
      2'b01:   count_nxt_s = count_r - (PTR_W+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO pointers, occupancy and entry storage; flush never touches queued results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= '0;
      end
    end else begin
      count_r <= count_nxt_s;
      if (res_hs_s) begin
        entry_r[wr_ptr_r] <= {mdv_o_wdat, mdv_o_err, pend_itag_r};
        wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  assign mdv_o_ready  = ~full_s;
  assign wbck_o_valid = ~empty_s;
  assign {wbck_o_wdat, wbck_o_err, wbck_o_itag} = entry_r[rd_ptr_r];
  assign issue_block  = pend_vld_r | full_s;
  assign buf_cnt      = count_r;

  e203_exu_muldiv_wbck_buf_chk #(
    .PTR_W (PTR_W),
    .DEPTH (DEPTH)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue_hs (issue_hs_s),
    .res_hs   (mdv_o_valid & mdv_o_ready),
    .pend_vld (pend_vld_r),
    .count    (count_r)
  );

endmodule

// Protocol checks on the issue/result handshakes around the pending tag.
module e203_exu_muldiv_wbck_buf_chk #(
  parameter int PTR_W = 1,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           issue_hs,
  input  logic           res_hs,
  input  logic           pend_vld,
  input  logic [PTR_W:0] count
);

  a_issue_while_pend: assert property (@(posedge clk) disable iff (!rst_n)
    !(issue_hs && pend_vld && !res_hs));

  a_res_without_pend: assert property (@(posedge clk) disable iff (!rst_n)
    !(res_hs && !pend_vld));

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(count) <= DEPTH));

endmodule
